avalon_mm_cmd_master: RTL and testbench
=======================================

// Module: avalon_mm_cmd_master
// PURPOSE
//  Upstream driver for the s0 Avalon-MM slave port of the program-logic block.
//  Buffers read/write commands in a small FIFO and issues them one at a time on m0_*.
//  Holds each transfer stable while m0_waitrequest is high; aborts a stuck transfer after TIMEOUT cycles.
//  Returns read data on a valid/ready response channel.
// PARAMETERS
//  ADDR_W     32    m0/cmd address width
//  DATA_W     32    m0/cmd/rsp data width
//  CMD_DEPTH  4     command FIFO entries, power of 2, >=2
//  TIMEOUT    2048  consecutive waitrequest-high cycles before abort; >=2, must exceed slave worst-case wait (1023)
// PORTS
//  clk             in   1       clock, all logic on posedge
//  reset           in   1       asynchronous, active-low reset
//  cmd_valid       in   1       command present
//  cmd_ready       out  1       FIFO can accept; equals !full, registered
//  cmd_write       in   1       1=write, 0=read
//  cmd_address     in   ADDR_W  target address, passed through unmodified
//  cmd_writedata   in   DATA_W  write payload, ignored for reads
//  m0_address      out  ADDR_W  Avalon address
//  m0_read         out  1       Avalon read strobe
//  m0_write        out  1       Avalon write strobe
//  m0_writedata    out  DATA_W  Avalon write data
//  m0_readdata     in   DATA_W  sampled only when m0_read=1 and m0_waitrequest=0
//  m0_waitrequest  in   1       slave stall
//  rsp_valid       out  1       read response present
//  rsp_ready       in   1       consumer accepts response
//  rsp_data        out  DATA_W  read data, 0 on error
//  rsp_error       out  1       response is a timeout abort
//  timeout_count   out  8       aborted transfers, reads+writes, saturates at 255
//  busy            out  1       state!=IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset, while low: FIFO emptied; state IDLE; m0_read/m0_write/rsp_valid/rsp_error=0.
//   m0_address/m0_writedata/rsp_data=0; timeout_count=0; wait counter=0.
//   cmd_ready returns to 1 the first cycle after release.
//  Push: cmd_valid&cmd_ready at an edge writes the FIFO. cmd_ready is from registered full.
//   When full, a push in the same cycle as a pop is still refused.
//  FSM IDLE -> ISSUE -> (IDLE | RESP):
//   IDLE: if FIFO non-empty, pop head into m0 regs and assert m0_read or m0_write; next state ISSUE.
//    Minimum latency: cmd accepted at edge T, strobe visible after edge T+1.
//   ISSUE, waitrequest=1: m0_* held bit-stable; wait counter increments.
//   ISSUE, waitrequest=0, write: strobe dropped at next edge; -> IDLE; no response generated.
//   ISSUE, waitrequest=0, read: capture m0_readdata into rsp_data; rsp_valid=1, rsp_error=0; strobe dropped; -> RESP.
//   Timeout, wait counter==TIMEOUT-1 with waitrequest still 1: drop strobe; timeout_count+=1 (saturating).
//    Read abort -> RESP with rsp_data=0, rsp_error=1.
//    Write abort -> IDLE silently.
//   RESP: rsp_valid/rsp_data/rsp_error held until rsp_valid&rsp_ready; then clear rsp_valid/rsp_error -> IDLE.
//    No new m0 transfer while in RESP; FIFO still accepts pushes.
//  Wait counter clears on every entry to ISSUE; counter width = clog2(TIMEOUT)+1.
//  At most one m0 transfer outstanding; m0_read and m0_write are never both 1.
//  Back-to-back commands: one IDLE bubble cycle between transfers.
//  Reset mid-transfer: strobes fall immediately (async); queued and in-flight commands are discarded.
// TESTING
//  1 write 0x5/0x1234, waitrequest=0 -> m0_write=1 for exactly 1 cycle, addr 0x5, data 0x1234; rsp_valid stays 0.
//  2 read 0x5; waitrequest high 3 cycles then low with readdata 0x2468 -> m0_* stable 4 cycles; rsp_data=0x2468, rsp_error=0.
//  3 waitrequest held high, push 6 cmds, CMD_DEPTH=4 -> 5 accepted (1 in flight + 4 queued); cmd_ready=0 on 6th.
//  4 TIMEOUT=16, read with waitrequest stuck high -> m0_read drops after 16 cycles; rsp_error=1, rsp_data=0, timeout_count=1.
//  5 read completes, rsp_ready=0 for 10 cycles -> rsp fields stable; no m0 strobe until handshake; then next queued cmd issues.
//  6 reset low mid-wait with 2 queued -> m0_read=0 at once; after release cmd_ready=1, busy=0, no rsp.

Source files
------------

// File: rtl/avalon_mm_cmd_master_if.sv
// Command, Avalon-MM master and read-response signal bundle for avalon_mm_cmd_master.
// The master modport is the command master's view; slave is the view of its surroundings.
interface avalon_mm_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_writedata;

    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_waitrequest;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_error;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
        output cmd_ready,
        output m0_address, m0_read, m0_write, m0_writedata,
        input  m0_readdata, m0_waitrequest,
        output rsp_valid, rsp_data, rsp_error,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata,
        input  cmd_ready,
        input  m0_address, m0_read, m0_write, m0_writedata,
        output m0_readdata, m0_waitrequest,
        input  rsp_valid, rsp_data, rsp_error,
        output rsp_ready
    );
endinterface

// File: rtl/avalon_mm_cmd_master.sv
// Queues read/write commands and issues them one at a time as Avalon-MM transfers.
// Strobe appears one edge after a command lands in the queue; stuck transfers abort after TIMEOUT cycles.
module avalon_mm_cmd_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_mm_cmd_master_if.master bus,
    output logic [7:0]            timeout_count,
    output logic                  busy
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(CMD_DEPTH);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    // ---------------- command queue ----------------
    cmd_t          mem_q [CMD_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          rdy_q, rdy_d;
    logic          push, pop, fifo_empty;
    cmd_t          push_dat, head;

    assign push       = bus.cmd_valid & rdy_q;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign push_dat   = '{wr: bus.cmd_write, addr: bus.cmd_address, data: bus.cmd_writedata};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Ready is a registered !full, so a pop never frees a slot for the same edge.
        rdy_d = (count_d != FULL_CNT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dat;
    end

    // ---------------- transfer FSM ----------------
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] m0_address_q, m0_address_d;
    logic [DATA_W-1:0] m0_writedata_q, m0_writedata_d;
    logic              m0_read_q, m0_read_d;
    logic              m0_write_q, m0_write_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_error_q, rsp_error_d;
    logic [7:0]        timeout_count_q, timeout_count_d;

    always_comb begin
        state_d         = state_q;
        m0_address_d    = m0_address_q;
        m0_writedata_d  = m0_writedata_q;
        m0_read_d       = m0_read_q;
        m0_write_d      = m0_write_q;
        wait_cnt_d      = wait_cnt_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_data_d      = rsp_data_q;
        rsp_error_d     = rsp_error_q;
        timeout_count_d = timeout_count_q;
        pop             = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop            = 1'b1;
                    m0_address_d   = head.addr;
                    m0_writedata_d = head.data;
                    m0_read_d      = !head.wr;
                    m0_write_d     = head.wr;
                    wait_cnt_d     = '0;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.m0_waitrequest) begin
                    m0_read_d  = 1'b0;
                    m0_write_d = 1'b0;
                    if (m0_read_q) begin
                        rsp_data_d  = bus.m0_readdata;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b0;
                        state_d     = RESP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Abort: reads still owe the consumer an (error) response, writes vanish.
                    m0_read_d  = 1'b0;
                    m0_write_d = 1'b0;
                    if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 1'b1;
                    if (m0_read_q) begin
                        rsp_data_d  = '0;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_error_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            m0_address_q    <= '0;
            m0_writedata_q  <= '0;
            m0_read_q       <= 1'b0;
            m0_write_q      <= 1'b0;
            wait_cnt_q      <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_error_q     <= 1'b0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            m0_address_q    <= m0_address_d;
            m0_writedata_q  <= m0_writedata_d;
            m0_read_q       <= m0_read_d;
            m0_write_q      <= m0_write_d;
            wait_cnt_q      <= wait_cnt_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_error_q     <= rsp_error_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign bus.cmd_ready    = rdy_q;
    assign bus.m0_address   = m0_address_q;
    assign bus.m0_writedata = m0_writedata_q;
    assign bus.m0_read      = m0_read_q;
    assign bus.m0_write     = m0_write_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_error    = rsp_error_q;
    assign timeout_count    = timeout_count_q;
    assign busy             = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_avalon_mm_cmd_master.sv
// Directed bench with a scoreboard: stimulus queues expected m0 transfers and responses, a monitor checks them.
module tb_avalon_mm_cmd_master;
    localparam int AW = 32;
    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] timeout_count;
    logic       busy;

    avalon_mm_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    avalon_mm_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .timeout_count(timeout_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } m0_exp_t;
    typedef struct { logic [DW-1:0] data; logic err; } rsp_exp_t;

    m0_exp_t  m0_q[$];
    rsp_exp_t rsp_q[$];
    int checks = 0;
    int errors = 0;
    int strobe_len = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit exp_m0, input bit exp_rsp, input logic [DW-1:0] rd, input logic re);
        if (exp_m0)  m0_q.push_back('{wr: wr, addr: a, data: d});
        if (exp_rsp) rsp_q.push_back('{data: rd, err: re});
        bus.cmd_valid     = 1'b1;
        bus.cmd_write     = wr;
        bus.cmd_address   = a;
        bus.cmd_writedata = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                @(posedge clk); #1;
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        bus.cmd_valid = 1'b0;
        checks++; errors++;
        $display("FAIL push_accept: addr 0x%0h never accepted", a);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && !bus.rsp_valid) begin
                @(posedge clk); #1;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL %s: still busy=%0b after bound", tag, busy);
    endtask

    task automatic wait_strobe(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.m0_read || bus.m0_write) return;
        end
        checks++; errors++;
        $display("FAIL %s: no m0 strobe within bound", tag);
    endtask

    // Scoreboard monitor: m0 completions, hold stability, responses.
    initial begin : monitor
        logic prev_on, prev_wait, pr, pw, on;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        int run;
        m0_exp_t  e;
        rsp_exp_t r;
        prev_on = 1'b0; prev_wait = 1'b0; pr = 1'b0; pw = 1'b0; pa = '0; pd = '0; run = 0;
        forever begin
            @(negedge clk);
            on = bus.m0_read | bus.m0_write;
            if (on) begin
                check("one_strobe", bus.m0_read & bus.m0_write, 0);
                if (prev_on && prev_wait)
                    check("m0_hold", {bus.m0_address, bus.m0_writedata, bus.m0_read, bus.m0_write}
                                     != {pa, pd, pr, pw}, 0);
                run++;
                if (!bus.m0_waitrequest) begin
                    if (m0_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL m0_unexpected: addr 0x%0h wr=%0b", bus.m0_address, bus.m0_write);
                    end else begin
                        e = m0_q.pop_front();
                        check("m0_kind", bus.m0_write, e.wr);
                        check("m0_addr", bus.m0_address, e.addr);
                        if (e.wr) check("m0_wdata", bus.m0_writedata, e.data);
                    end
                end
            end else begin
                if (run > 0) strobe_len = run;
                run = 0;
            end
            prev_on = on; prev_wait = bus.m0_waitrequest;
            pa = bus.m0_address; pd = bus.m0_writedata; pr = bus.m0_read; pw = bus.m0_write;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: data 0x%0h err=%0b", bus.rsp_data, bus.rsp_error);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_data", bus.rsp_data, r.data);
                    check("rsp_error", bus.rsp_error, r.err);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = '0; bus.cmd_writedata = '0;
        bus.m0_readdata = '0; bus.m0_waitrequest = 1'b0; bus.rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m0_read", bus.m0_read, 0);
        check("rst_m0_write", bus.m0_write, 0);
        check("rst_m0_addr", bus.m0_address, 0);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_error, bus.rsp_data}, 0);
        check("rst_tmo", timeout_count, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rel_cmd_ready", bus.cmd_ready, 1);

        // 1: single write, no wait
        @(posedge clk); #1;
        push(1'b1, 32'h5, 32'h1234, 1, 0, '0, 1'b0);
        @(negedge clk);
        check("t1_latency_early", bus.m0_write, 0);
        @(negedge clk);
        check("t1_latency_on", bus.m0_write, 1);
        wait_idle("t1_idle");
        check("t1_strobe_len", strobe_len, 1);

        // 2: read with 3 wait cycles
        bus.m0_waitrequest = 1'b1;
        push(1'b0, 32'h5, '0, 1, 1, 32'h2468, 1'b0);
        wait_strobe("t2_strobe");
        repeat (3) @(posedge clk);
        #1;
        bus.m0_waitrequest = 1'b0;
        bus.m0_readdata = 32'h2468;
        wait_idle("t2_idle");
        check("t2_strobe_len", strobe_len, 4);

        // 3: stalled slave, fill queue
        bus.m0_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++)
            push(1'b1, 32'h100 + i, 32'hA0 + i, 1, 0, '0, 1'b0);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_address = 32'h1FF; bus.cmd_writedata = 32'hFF;
        @(negedge clk);
        check("t3_full_ready", bus.cmd_ready, 0);
        check("t3_busy", busy, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.m0_waitrequest = 1'b0;
        wait_idle("t3_idle");
        check("t3_tmo", timeout_count, 0);

        // 4: read and write timeouts
        bus.m0_waitrequest = 1'b1;
        push(1'b0, 32'h40, '0, 0, 1, 32'h0, 1'b1);
        wait_idle("t4_idle_rd");
        check("t4_rd_strobe_len", strobe_len, 16);
        check("t4_tmo_1", timeout_count, 1);
        push(1'b1, 32'h44, 32'h77, 0, 0, '0, 1'b0);
        wait_idle("t4_idle_wr");
        check("t4_wr_strobe_len", strobe_len, 16);
        check("t4_tmo_2", timeout_count, 2);

        // 5: response backpressure blocks next transfer
        bus.m0_waitrequest = 1'b0;
        bus.m0_readdata = 32'hABCD;
        bus.rsp_ready = 1'b0;
        push(1'b0, 32'h77, '0, 1, 1, 32'hABCD, 1'b0);
        push(1'b1, 32'h78, 32'h55, 1, 0, '0, 1'b0);
        for (int i = 0; i < 50 && !bus.rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("t5_rsp_hold", {bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.m0_read | bus.m0_write},
                  {1'b1, 32'hABCD, 1'b0, 1'b0});
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_idle("t5_idle");

        // 6: reset mid-wait with queued commands
        bus.m0_waitrequest = 1'b1;
        push(1'b0, 32'h90, '0, 0, 0, '0, 1'b0);
        push(1'b1, 32'h91, 32'h1, 0, 0, '0, 1'b0);
        push(1'b1, 32'h92, 32'h2, 0, 0, '0, 1'b0);
        check("t6_pre_read", bus.m0_read, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_read", bus.m0_read, 0);
        check("t6_async_busy", busy, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.m0_waitrequest = 1'b0;
        @(posedge clk); @(negedge clk);
        check("t6_cmd_ready", bus.cmd_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_rsp_valid", bus.rsp_valid, 0);
        repeat (20) @(negedge clk);

        check("m0_q_empty", m0_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
